jk_ff_bank: RTL and testbench

JK_FF_BANK -- requirements
Module: jk_ff_bank

---
 rtl/jk_ff_bank.sv | 81 ++++++++
 tb/tb_jk_ff_bank.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/jk_ff_bank.sv
// jk_ff_bank: bank of independent JK flip-flops emulated on mclk, master-slave or negative-edge behaviour.
// Define JK_PRESET_EN to add the per-channel pre_n preset input and its logic.
module jk_ff_bank #(
   parameter int WIDTH      = 2,
   parameter int SYNC_DEPTH = 2,
   parameter int EDGE_MODE  = 0
) (
   input  logic             mclk,
   input  logic             mrst_n,
   input  logic [WIDTH-1:0] clk_n,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] clr_n,
`ifdef JK_PRESET_EN
   input  logic [WIDTH-1:0] pre_n,
`endif
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_n
);
   logic [WIDTH-1:0] pre_v, clk_d, clr_d, pre_d, master, jd, kd;
   logic [WIDTH-1:0] rise, fall, clr_q, pre_q, hold, cap, m_jk, q_jk;
   logic [WIDTH-1:0] m_nrm, q_nrm, qn_nrm, m_nxt, q_nxt, qn_nxt;
   logic [WIDTH-1:0] j_sr [SYNC_DEPTH];
   logic [WIDTH-1:0] k_sr [SYNC_DEPTH];
`ifdef JK_PRESET_EN
   assign pre_v = pre_n;
`else
   assign pre_v = '1;
`endif
   assign jd = j_sr[SYNC_DEPTH-1];
   assign kd = k_sr[SYNC_DEPTH-1];
   always_comb begin
      rise   = clk_n & ~clk_d;
      fall   = ~clk_n & clk_d;
      clr_q  = ~clr_n & ~clr_d;
      pre_q  = ~pre_v & ~pre_d;
      hold   = clr_q | pre_q;
      m_jk   = (jd & ~master) | (~kd & master);
      q_jk   = (jd & ~q) | (~kd & q);
      // releasing clear/preset with the clock already high captures like a rise
      cap    = rise | (clk_n & clr_n & ~clr_d) | (clk_n & pre_v & ~pre_d);
      m_nrm  = (cap & m_jk) | (~cap & master);
      q_nrm  = (fall & master) | (~fall & q);
      qn_nrm = (fall & ~master) | (~fall & q_n);
      if (EDGE_MODE != 0) begin
         m_nrm  = (fall & q_jk) | (~fall & master);
         q_nrm  = (fall & q_jk) | (~fall & q);
         qn_nrm = (fall & ~q_jk) | (~fall & q_n);
      end
      m_nxt  = (pre_q & ~clr_q) | (~hold & m_nrm);
      q_nxt  = pre_q | (~hold & q_nrm);
      qn_nxt = clr_q | (~hold & qn_nrm);
   end
   always_ff @(posedge mclk) begin
      if (!mrst_n) begin
         clk_d  <= '1;
         clr_d  <= '1;
         pre_d  <= '1;
         master <= '0;
         q      <= '0;
         q_n    <= '1;
         for (int s = 0; s < SYNC_DEPTH; s++) begin
            j_sr[s] <= '0;
            k_sr[s] <= '0;
         end
      end else begin
         clk_d   <= clk_n;
         clr_d   <= clr_n;
         pre_d   <= pre_v;
         master  <= m_nxt;
         q       <= q_nxt;
         q_n     <= qn_nxt;
         j_sr[0] <= j;
         k_sr[0] <= k;
         for (int s = 1; s < SYNC_DEPTH; s++) begin
            j_sr[s] <= j_sr[s-1];
            k_sr[s] <= k_sr[s-1];
         end
      end
   end
endmodule

// File: tb/tb_jk_ff_bank.sv
// tb_jk_ff_bank: directed checks of jk_ff_bank, master-slave and negative-edge instances side by side.
module tb_jk_ff_bank;
   logic       mclk = 1'b0;
   logic       mrst_n;
   logic [1:0] clk_n, j, k, clr_n, q, q_n, q1, q1_n;
`ifdef JK_PRESET_EN
   logic [1:0] pre_n;
`endif
   int checks = 0;
   int errors = 0;

   always #5 mclk = ~mclk;

   jk_ff_bank #(.WIDTH(2), .SYNC_DEPTH(2), .EDGE_MODE(0)) u_dut (
      .mclk(mclk), .mrst_n(mrst_n), .clk_n(clk_n), .j(j), .k(k), .clr_n(clr_n),
`ifdef JK_PRESET_EN
      .pre_n(pre_n),
`endif
      .q(q), .q_n(q_n)
   );

   jk_ff_bank #(.WIDTH(2), .SYNC_DEPTH(2), .EDGE_MODE(1)) u_dut1 (
      .mclk(mclk), .mrst_n(mrst_n), .clk_n(clk_n), .j(j), .k(k), .clr_n(clr_n),
`ifdef JK_PRESET_EN
      .pre_n(pre_n),
`endif
      .q(q1), .q_n(q1_n)
   );

   task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %b exp %b", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge mclk);
      #1;
   endtask

   initial begin
      mrst_n = 1'b0;
      for (int c = 0; c < 2; c++) begin
         clk_n = 2'($urandom_range(3));
         j     = 2'($urandom_range(3));
         k     = 2'($urandom_range(3));
         clr_n = 2'($urandom_range(3));
`ifdef JK_PRESET_EN
         pre_n = 2'($urandom_range(3));
`endif
         step(1);
      end
      chk("rst_q", q, 2'b00);
      chk("rst_qn", q_n, 2'b11);
      chk("rst_q1", q1, 2'b00);
      mrst_n = 1'b1;
      clk_n  = 2'b11;
      j      = 2'b00;
      k      = 2'b00;
      clr_n  = 2'b11;
`ifdef JK_PRESET_EN
      pre_n  = 2'b11;
`endif
      step(3);
      chk("rel_q", q, 2'b00);
      chk("rel_qn", q_n, 2'b11);
      // set then reset on ch0
      j = 2'b01; clk_n = 2'b10;
      step(3);
      chk("sr_pre", q, 2'b00);
      clk_n = 2'b11; step(1);
      chk("sr_rise", q, 2'b00);
      clk_n = 2'b10; step(1);
      chk("sr_set", q, 2'b01);
      chk("sr_set_n", q_n, 2'b10);
      j = 2'b00; k = 2'b01;
      step(3);
      clk_n = 2'b11; step(1);
      chk("sr_hold", q, 2'b01);
      clk_n = 2'b10; step(1);
      chk("sr_clr", q, 2'b00);
      chk("sr_clr_n", q_n, 2'b11);
      // toggle ch1 with one-cycle-high clock pulses
      j = 2'b11; k = 2'b11; clk_n = 2'b00;
      step(3);
      for (int p = 0; p < 4; p++) begin
         clk_n = 2'b10; step(1);
         clk_n = 2'b00; step(1);
         chk("tog_q", q, (p % 2 == 0) ? 2'b10 : 2'b00);
         chk("tog_qn", q_n, (p % 2 == 0) ? 2'b01 : 2'b11);
      end
      // j/k changed one cycle before the rise: delayed (old) toggle still applies
      j = 2'b00; k = 2'b11; step(1);
      clk_n = 2'b10; step(1);
      clk_n = 2'b00; step(1);
      chk("old_jk", q, 2'b10);
      // clear on ch0
      j = 2'b01; k = 2'b10;
      step(2);
      clk_n = 2'b01; step(1);
      clk_n = 2'b00; step(1);
      chk("clr_setup", q, 2'b11);
      clr_n = 2'b10; step(1);
      clr_n = 2'b11; step(1);
      chk("clr_glitch", q, 2'b11);
      clr_n = 2'b10; step(1);
      chk("clr_1cyc", q, 2'b11);
      step(1);
      chk("clr_q", q, 2'b10);
      chk("clr_qn", q_n, 2'b01);
      clk_n = 2'b01; step(1);
      chk("clr_ignore", q, 2'b10);
      clr_n = 2'b11; step(1);
      chk("clr_rel", q, 2'b10);
      clk_n = 2'b00; step(1);
      chk("clr_recap", q, 2'b11);
`ifdef JK_PRESET_EN
      clr_n = 2'b01; step(2);
      chk("pc_clr", q, 2'b01);
      clr_n = 2'b11; pre_n = 2'b01; step(1);
      chk("pre_1cyc", q, 2'b01);
      step(1);
      chk("pre_q", q, 2'b11);
      chk("pre_qn", q_n, 2'b00);
      pre_n = 2'b11; step(1);
      pre_n = 2'b01; clr_n = 2'b01; step(2);
      chk("both_q", q, 2'b11);
      chk("both_qn", q_n, 2'b10);
      pre_n = 2'b11; clr_n = 2'b11; step(1);
      chk("both_hold", q_n, 2'b10);
      clk_n = 2'b10; step(1);
      clk_n = 2'b00; step(1);
      chk("both_pulse", q, 2'b01);
      chk("both_pulse_n", q_n, 2'b10);
`endif
      // negative-edge instance versus master-slave instance
      mrst_n = 1'b0; clk_n = 2'b01; j = 2'b11; k = 2'b11;
      step(1);
      chk("rst2_q", q, 2'b00);
      chk("rst2_q1", q1, 2'b00);
      mrst_n = 1'b1; clk_n = 2'b11; clr_n = 2'b11;
      step(3);
      chk("m1_idle", q1, 2'b00);
      clk_n = 2'b01; step(1);
      chk("m1_fall", q1, 2'b10);
      chk("m1_fall_n", q1_n, 2'b01);
      chk("m0_fall", q, 2'b00);
      clk_n = 2'b11; step(1);
      chk("m1_rise", q1, 2'b10);
      clk_n = 2'b01; step(1);
      chk("m1_fall2", q1, 2'b00);
      chk("m0_pulse", q, 2'b10);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
